score_keeper: RTL and testbench
===============================

SCORE_KEEPER -- requirements
Module: score_keeper

Interface
REQ-001 Parameter WIN_SCORE, default 9: score value that ends a game; legal range 1..15.
REQ-002 Parameter PAUSE_FRAMES, default 120: frame ticks spent in POINT before the next serve; legal range 1..255.
REQ-003 Parameter FLASH_FRAMES, default 8: frame ticks per score-flash half-period; legal range 1..255.
REQ-004 clk  input  1  system clock; the only clock.
REQ-005 rst  input  1  reset; synchronous, active-low.
REQ-006 frame_tick  input  1  one-cycle pulse at the start of vertical blanking.
REQ-007 start_btn  input  1  one-cycle pulse; starts a game.
REQ-008 launch  input  1  one-cycle pulse; the ball has been served.
REQ-009 point_you  input  1  one-cycle pulse; the local player won the rally.
REQ-010 point_them  input  1  one-cycle pulse; the remote player won the rally.
REQ-011 your_score  output  16  local score; bits [15:4] are always 0.
REQ-012 their_score  output  16  remote score; bits [15:4] are always 0.
REQ-013 game_state  output  16  {13'b0, state code}.
REQ-014 winner  output  2  00 none, 01 you, 10 them.
REQ-015 score_vis  output  1  1 = score digits are drawn.

Function
REQ-016 State codes: IDLE=0, SERVE=1, PLAY=2, POINT=3, OVER=4; all outputs are registered.
REQ-017 Transitions:
- IDLE: start_btn -> SERVE, both scores cleared.
- SERVE: launch -> PLAY.
- PLAY: point event latched -> pending.
- POINT: counts down, then -> OVER or SERVE (REQ-020).
- OVER: start_btn -> SERVE, scores and winner cleared.
REQ-018 In PLAY, the first point pulse is latched into a pending flag; later point pulses are ignored until the flag is consumed; if point_you and point_them arrive in the same cycle, point_you wins and point_them is dropped.
REQ-019 On the first frame_tick with a pending point:
- the matching score increments, with visible effect on the next cycle;
- the pending flag clears;
- pause counter loads PAUSE_FRAMES;
- state -> POINT.
Scores therefore change only at frame boundaries.
REQ-020 In POINT, each frame_tick decrements the pause counter; on the tick where it reaches 0:
- if either score equals WIN_SCORE: state -> OVER and winner is set;
- otherwise: state -> SERVE.
REQ-021 A score never exceeds WIN_SCORE: an increment at WIN_SCORE saturates and cannot occur in practice.
REQ-022 Inputs that are not valid for the current state are ignored: start_btn outside IDLE/OVER, launch outside SERVE, point pulses outside PLAY.
REQ-023 frame_tick coincident with a point pulse: the pulse is latched this cycle and applied on the next frame_tick.
REQ-024 Transition latency: one clk cycle from the qualifying input (or frame_tick) to updated outputs.

Reset
REQ-025 While rst=0 at a clk edge: state=IDLE, scores=0, winner=00, pending=0, counters=0, score_vis=1.
REQ-026 Reset applied mid-game overrides all inputs in that cycle; no pending point survives reset.

Configuration
REQ-027 Macro SCORE_FLASH_EN:
- When defined: in POINT, score_vis toggles every FLASH_FRAMES frame ticks, starting at 1 on entry; it is forced to 1 on leaving POINT.
- When not defined: score_vis is constant 1 and no flash counter is built.

Structure
REQ-028 Shared package holds the state-code constants (IDLE..OVER) and the winner encodings, so display logic can decode game_state.
REQ-029 One sub-module, frame_counter: a loadable down-counter decremented on frame_tick with a zero flag; used for the pause and, with SCORE_FLASH_EN, the flash.

Verification
REQ-030 Reset, then start_btn -> game_state=1, scores 0, winner 00, score_vis 1.
REQ-031 In PLAY, point_them then frame_tick -> their_score=1 the next cycle, game_state=3; after 120 frame_ticks, game_state=1.
REQ-032 point_you and point_them in the same cycle, then a second point_them before frame_tick -> only your_score increments by 1.
REQ-033 your_score=8, point_you, frame_tick, then 120 ticks -> your_score=9, game_state=4, winner=01; a following start_btn -> SERVE with 0:0.
REQ-034 rst=0 asserted during POINT with a pending point -> next cycle IDLE, all outputs at reset values.
REQ-035 With SCORE_FLASH_EN defined, during POINT -> score_vis pattern 1 for 8 ticks, 0 for 8 ticks; without the macro -> constant 1.

Source files
------------

// File: rtl/score_keeper_pkg.sv
// Shared constants for the score keeper and for display logic that decodes
// its outputs.
//   - state codes (IDLE..OVER) as driven on game_state[2:0]
//   - winner encodings as driven on winner[1:0]
//   - score / frame-counter widths and a saturating score increment helper
package score_keeper_pkg;

   localparam logic [2:0] ST_IDLE  = 3'd0;
   localparam logic [2:0] ST_SERVE = 3'd1;
   localparam logic [2:0] ST_PLAY  = 3'd2;
   localparam logic [2:0] ST_POINT = 3'd3;
   localparam logic [2:0] ST_OVER  = 3'd4;

   localparam logic [1:0] WIN_NONE = 2'b00;
   localparam logic [1:0] WIN_YOU  = 2'b01;
   localparam logic [1:0] WIN_THEM = 2'b10;

   localparam int unsigned SCORE_W     = 4;
   localparam int unsigned FRAME_CNT_W = 8;

   // Scores stop at the winning value; reaching it ends the game, so the
   // held case only guards against an impossible extra point.
   function automatic logic [SCORE_W-1:0] sat_inc(input logic [SCORE_W-1:0] val,
                                                  input logic [SCORE_W-1:0] lim);
      return (val >= lim) ? val : val + {{(SCORE_W-1){1'b0}}, 1'b1};
   endfunction

endpackage

// File: rtl/score_keeper_frame_counter.sv
// Loadable down-counter stepped by frame ticks.
// Ports:
//   clk       system clock
//   rst       synchronous active-low reset (count -> 0)
//   tick      decrement enable (one frame tick); holds at zero
//   load      load load_val this cycle (takes priority over tick)
//   load_val  value to load
//   zero      count is zero
//   expire    terminal-count strobe: this tick takes the count from 1 to 0
module frame_counter #(
   parameter int unsigned W = 8
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         tick,
   input  logic         load,
   input  logic [W-1:0] load_val,
   output logic         zero,
   output logic         expire
);

   logic [W-1:0] count_q;
   logic [W-1:0] count_d;

   always_comb begin
      count_d = count_q;
      if (load) begin
         count_d = load_val;
      end else if (tick && (count_q != '0)) begin
         count_d = count_q - W'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

   assign zero   = (count_q == '0);
   assign expire = tick && (count_q == W'(1));

endmodule

// File: rtl/score_keeper.sv
// Pong-style score keeper: game FSM, score registers and point pause timer.
// Optional macro SCORE_FLASH_EN: flash the score digits while in POINT.
// Ports:
//   clk          system clock
//   rst          synchronous active-low reset
//   frame_tick   pulse at start of vertical blanking
//   start_btn    start a game (IDLE/OVER only)
//   launch       ball served (SERVE only)
//   point_you    local player won the rally (PLAY only)
//   point_them   remote player won the rally (PLAY only)
//   your_score   {12'b0, local score}
//   their_score  {12'b0, remote score}
//   game_state   {13'b0, state code}
//   winner       00 none, 01 you, 10 them
//   score_vis    1 = draw score digits
//
// state | meaning
// ------+-------------------------------------------------------------
// IDLE  | power-up, waiting for start_btn
// SERVE | waiting for the ball to be launched
// PLAY  | rally in progress; first point pulse latched as pending
// POINT | pause after a point, counting PAUSE_FRAMES frame ticks
// OVER  | a player reached WIN_SCORE; waiting for start_btn
module score_keeper
   import score_keeper_pkg::*;
#(
   parameter int unsigned WIN_SCORE    = 9,
   parameter int unsigned PAUSE_FRAMES = 120,
   parameter int unsigned FLASH_FRAMES = 8
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        frame_tick,
   input  logic        start_btn,
   input  logic        launch,
   input  logic        point_you,
   input  logic        point_them,
   output logic [15:0] your_score,
   output logic [15:0] their_score,
   output logic [15:0] game_state,
   output logic [1:0]  winner,
   output logic        score_vis
);

   localparam logic [SCORE_W-1:0]     WIN_Q   = WIN_SCORE[SCORE_W-1:0];
   localparam logic [FRAME_CNT_W-1:0] PAUSE_Q = PAUSE_FRAMES[FRAME_CNT_W-1:0];

   logic [2:0]         state_q,    state_d;
   logic [SCORE_W-1:0] you_q,      you_d;
   logic [SCORE_W-1:0] them_q,     them_d;
   logic [1:0]         winner_q,   winner_d;
   logic               pend_q,     pend_d;
   logic               pend_you_q, pend_you_d;
   logic               vis_q,      vis_d;

   logic pause_load;
   logic pause_zero;
   logic pause_expire;

   frame_counter #(.W(FRAME_CNT_W)) u_pause (
      .clk      (clk),
      .rst      (rst),
      .tick     (frame_tick),
      .load     (pause_load),
      .load_val (PAUSE_Q),
      .zero     (pause_zero),
      .expire   (pause_expire)
   );

   always_comb begin
      state_d    = state_q;
      you_d      = you_q;
      them_d     = them_q;
      winner_d   = winner_q;
      pend_d     = pend_q;
      pend_you_d = pend_you_q;
      pause_load = 1'b0;
      case (state_q)
         ST_IDLE, ST_OVER: begin
            if (start_btn) begin
               state_d  = ST_SERVE;
               you_d    = '0;
               them_d   = '0;
               winner_d = WIN_NONE;
            end
         end
         ST_SERVE: begin
            if (launch) begin
               state_d = ST_PLAY;
            end
         end
         ST_PLAY: begin
            // A pulse coincident with the tick that consumes the pending
            // point is dropped; one coincident with a tick while nothing is
            // pending is latched and waits for the following tick.
            if (frame_tick && pend_q) begin
               if (pend_you_q) begin
                  you_d = sat_inc(you_q, WIN_Q);
               end else begin
                  them_d = sat_inc(them_q, WIN_Q);
               end
               pend_d     = 1'b0;
               pause_load = 1'b1;
               state_d    = ST_POINT;
            end else if (!pend_q && (point_you || point_them)) begin
               pend_d     = 1'b1;
               pend_you_d = point_you;
            end
         end
         ST_POINT: begin
            if (pause_expire) begin
               if (you_q == WIN_Q) begin
                  state_d  = ST_OVER;
                  winner_d = WIN_YOU;
               end else if (them_q == WIN_Q) begin
                  state_d  = ST_OVER;
                  winner_d = WIN_THEM;
               end else begin
                  state_d = ST_SERVE;
               end
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

`ifdef SCORE_FLASH_EN
   logic                   flash_load;
   logic [FRAME_CNT_W-1:0] flash_val;
   logic                   flash_zero;
   logic                   flash_expire;

   frame_counter #(.W(FRAME_CNT_W)) u_flash (
      .clk      (clk),
      .rst      (rst),
      .tick     (frame_tick),
      .load     (flash_load),
      .load_val (flash_val),
      .zero     (flash_zero),
      .expire   (flash_expire)
   );

   // Leaving POINT wins over a coincident half-period expiry so the digits
   // are always shown outside POINT; the counter is parked at zero there.
   always_comb begin
      vis_d      = vis_q;
      flash_load = 1'b0;
      flash_val  = FLASH_FRAMES[FRAME_CNT_W-1:0];
      if ((state_q != ST_POINT) && (state_d == ST_POINT)) begin
         vis_d      = 1'b1;
         flash_load = 1'b1;
      end else if ((state_q == ST_POINT) && (state_d != ST_POINT)) begin
         vis_d      = 1'b1;
         flash_load = 1'b1;
         flash_val  = '0;
      end else if ((state_q == ST_POINT) && flash_expire) begin
         vis_d      = ~vis_q;
         flash_load = 1'b1;
      end
   end

   logic unused_zero;
   assign unused_zero = pause_zero ^ flash_zero;
`else
   localparam int unsigned flash_frames_unused = FLASH_FRAMES;

   always_comb begin
      vis_d = 1'b1;
   end

   logic unused_zero;
   assign unused_zero = pause_zero;
`endif

   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q    <= ST_IDLE;
         you_q      <= '0;
         them_q     <= '0;
         winner_q   <= WIN_NONE;
         pend_q     <= 1'b0;
         pend_you_q <= 1'b0;
         vis_q      <= 1'b1;
      end else begin
         state_q    <= state_d;
         you_q      <= you_d;
         them_q     <= them_d;
         winner_q   <= winner_d;
         pend_q     <= pend_d;
         pend_you_q <= pend_you_d;
         vis_q      <= vis_d;
      end
   end

   assign your_score  = {{(16-SCORE_W){1'b0}}, you_q};
   assign their_score = {{(16-SCORE_W){1'b0}}, them_q};
   assign game_state  = {13'b0, state_q};
   assign winner      = winner_q;
   assign score_vis   = vis_q;

endmodule

// File: tb/tb_score_keeper.sv
module tb_score_keeper;

   logic        clk;
   logic        rst;
   logic        frame_tick;
   logic        start_btn;
   logic        launch;
   logic        point_you;
   logic        point_them;
   logic [15:0] your_score;
   logic [15:0] their_score;
   logic [15:0] game_state;
   logic [1:0]  winner;
   logic        score_vis;

   score_keeper dut (
      .clk         (clk),
      .rst         (rst),
      .frame_tick  (frame_tick),
      .start_btn   (start_btn),
      .launch      (launch),
      .point_you   (point_you),
      .point_them  (point_them),
      .your_score  (your_score),
      .their_score (their_score),
      .game_state  (game_state),
      .winner      (winner),
      .score_vis   (score_vis)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      string       name;
      logic [15:0] you;
      logic [15:0] them;
      logic [15:0] st;
      logic [1:0]  win;
      logic        vis;
   } exp_t;

   exp_t exp_q[$];
   int   n_cmp = 0;
   int   n_err = 0;

   // Monitor: outputs settle after the rising edge; every expectation queued
   // since the last falling edge is checked here.
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            n_cmp++;
            if ({your_score, their_score, game_state, winner, score_vis} !==
                {e.you, e.them, e.st, e.win, e.vis}) begin
               n_err++;
               $display("FAIL %s: got you=%0d them=%0d st=%0d win=%b vis=%b, want you=%0d them=%0d st=%0d win=%b vis=%b",
                        e.name, your_score, their_score, game_state, winner, score_vis,
                        e.you, e.them, e.st, e.win, e.vis);
            end
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached, compared=%0d", n_cmp);
      $fatal(1);
   end

   task automatic expect_out(input string nm, input int y, input int t, input int st,
                             input int w, input bit v);
      exp_t e;
      e.name = nm;
      e.you  = 16'(y);
      e.them = 16'(t);
      e.st   = 16'(st);
      e.win  = 2'(w);
      e.vis  = v;
      exp_q.push_back(e);
   endtask

   task automatic drive(input bit s, input bit l, input bit py, input bit pt, input bit ft);
      @(negedge clk);
      start_btn  = s;
      launch     = l;
      point_you  = py;
      point_them = pt;
      frame_tick = ft;
      @(posedge clk);
      #1;
      start_btn  = 1'b0;
      launch     = 1'b0;
      point_you  = 1'b0;
      point_them = 1'b0;
      frame_tick = 1'b0;
   endtask

   // Reset with every pulse input asserted: reset must override them.
   task automatic reset_pulse(input string nm);
      @(negedge clk);
      rst        = 1'b0;
      start_btn  = 1'b1;
      launch     = 1'b1;
      point_you  = 1'b1;
      point_them = 1'b1;
      frame_tick = 1'b1;
      @(posedge clk);
      #1;
      expect_out(nm, 0, 0, 0, 0, 1'b1);
      start_btn  = 1'b0;
      launch     = 1'b0;
      point_you  = 1'b0;
      point_them = 1'b0;
      frame_tick = 1'b0;
      @(negedge clk);
      rst = 1'b1;
   endtask

   // Expected score_vis after n frame ticks spent in POINT (half-period 8).
   function automatic bit vis_exp(input int n);
`ifdef SCORE_FLASH_EN
      return ((n / 8) % 2) == 0;
`else
      return (n >= 0);
`endif
   endfunction

   // 120 frame ticks in POINT; stray start/launch/point pulses are injected
   // a few times and must have no effect.
   task automatic run_pause(input string nm, input int y, input int t,
                            input int end_st, input int end_w);
      for (int i = 1; i <= 120; i++) begin
         drive(i == 5, i == 6, i == 7, i == 7, 1'b1);
         if (i < 120) expect_out(nm, y, t, 3, 0, vis_exp(i));
         else         expect_out({nm, "_end"}, y, t, end_st, end_w, 1'b1);
      end
   endtask

   // Launch, one point for the named player, tick, then the full pause.
   task automatic play_point(input string nm, input bit you_pt, input int y0, input int t0,
                             input int end_st, input int end_w);
      int y1;
      int t1;
      y1 = you_pt ? y0 + 1 : y0;
      t1 = you_pt ? t0 : t0 + 1;
      drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
      expect_out({nm, "_launch"}, y0, t0, 2, 0, 1'b1);
      drive(1'b0, 1'b0, you_pt, !you_pt, 1'b0);
      expect_out({nm, "_latched"}, y0, t0, 2, 0, 1'b1);
      drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
      expect_out({nm, "_scored"}, y1, t1, 3, 0, 1'b1);
      run_pause({nm, "_pause"}, y1, t1, end_st, end_w);
   endtask

   initial begin
      rst        = 1'b0;
      frame_tick = 1'b0;
      start_btn  = 1'b0;
      launch     = 1'b0;
      point_you  = 1'b0;
      point_them = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      expect_out("reset", 0, 0, 0, 0, 1'b1);
      @(negedge clk);
      rst = 1'b1;

      drive(1'b0, 1'b1, 1'b1, 1'b1, 1'b1);
      expect_out("idle_ignore", 0, 0, 0, 0, 1'b1);
      drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
      expect_out("start", 0, 0, 1, 0, 1'b1);
      drive(1'b1, 1'b0, 1'b1, 1'b1, 1'b1);
      expect_out("serve_ignore", 0, 0, 1, 0, 1'b1);

      // remote point, full pause back to SERVE
      play_point("them1", 1'b0, 0, 0, 1, 0);

      // simultaneous pulses: you wins, later point_them dropped
      drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
      expect_out("both_launch", 0, 1, 2, 0, 1'b1);
      drive(1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
      expect_out("both_latch", 0, 1, 2, 0, 1'b1);
      drive(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
      expect_out("second_them", 0, 1, 2, 0, 1'b1);
      drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
      expect_out("both_scored", 1, 1, 3, 0, 1'b1);
      run_pause("both_pause", 1, 1, 1, 0);

      // point coincident with frame_tick is applied on the next tick
      drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
      expect_out("coin_launch", 1, 1, 2, 0, 1'b1);
      drive(1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
      expect_out("coin_latch", 1, 1, 2, 0, 1'b1);
      drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
      expect_out("coin_scored", 2, 1, 3, 0, 1'b1);
      run_pause("coin_pause", 2, 1, 1, 0);

      for (int y = 2; y < 8; y++) begin
         play_point("you_run", 1'b1, y, 1, 1, 0);
      end

      // winning point
      play_point("win", 1'b1, 8, 1, 4, 1);
      drive(1'b0, 1'b1, 1'b1, 1'b1, 1'b1);
      expect_out("over_ignore", 9, 1, 4, 1, 1'b1);
      drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
      expect_out("restart", 0, 0, 1, 0, 1'b1);

      // reset with a pending point; nothing may survive it
      drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
      expect_out("rst_launch", 0, 0, 2, 0, 1'b1);
      drive(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
      expect_out("rst_pending", 0, 0, 2, 0, 1'b1);
      reset_pulse("rst_play");
      drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
      expect_out("rst_start", 0, 0, 1, 0, 1'b1);
      drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
      expect_out("rst_launch2", 0, 0, 2, 0, 1'b1);
      drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
      expect_out("no_stale_point", 0, 0, 2, 0, 1'b1);

      // reset in the middle of POINT
      drive(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
      expect_out("mid_latch", 0, 0, 2, 0, 1'b1);
      drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
      expect_out("mid_scored", 1, 0, 3, 0, 1'b1);
      for (int i = 1; i <= 10; i++) begin
         drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
         expect_out("mid_point", 1, 0, 3, 0, vis_exp(i));
      end
      reset_pulse("rst_point");

      repeat (3) @(negedge clk);
      if (exp_q.size() != 0) begin
         n_cmp++;
         n_err++;
         $display("FAIL drain: %0d expectations left, want 0", exp_q.size());
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
